// File: rtl/lsu_pkg.sv
// Shared types for the load/store scheduler: the queued memory-op record
// and the issue FSM state encoding.
package lsu_pkg;

    localparam int LSU_DATA_WIDTH = 32;
    localparam int LSU_ROB_WIDTH  = 4;
    localparam int LSU_PREG_WIDTH = 7;

    typedef struct packed {
        logic                      is_store;
        logic [LSU_DATA_WIDTH-1:0] base;
        logic [LSU_DATA_WIDTH-1:0] offset;
        logic [LSU_DATA_WIDTH-1:0] sdata;
        logic [LSU_PREG_WIDTH-1:0] prd;
        logic [LSU_ROB_WIDTH-1:0]  rob_tag;
    } mem_op_t;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_STORE_WAIT = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/lsu_op_fifo.sv
// In-order circular FIFO of memory ops with occupancy count. Pointers wrap
// naturally because DEPTH is a power of two. Payload storage is never reset.
module lsu_op_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  mem_op_t                push_op,
    input  logic                   pop,
    output mem_op_t                head_op,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    mem_op_t            mem [DEPTH];
    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;

    // Pointer and occupancy bookkeeping; flush empties the queue like reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload write at the tail; the caller never pushes when full.
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= push_op;
    end

    assign head_op = mem[head_ptr];

endmodule

// File: rtl/lsu_scheduler.sv
// Memory-op scheduler: queues dispatched loads/stores, issues them to the LSU
// in strict program order, holds stores until they reach the ROB head, and
// tracks which in-flight loads were killed by a flush.
module lsu_scheduler
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int PREG_WIDTH = 7,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_enq_valid,
    output logic                   o_enq_ready,
    input  logic                   i_enq_is_store,
    input  logic [DATA_WIDTH-1:0]  i_enq_base,
    input  logic [DATA_WIDTH-1:0]  i_enq_offset,
    input  logic [DATA_WIDTH-1:0]  i_enq_sdata,
    input  logic [PREG_WIDTH-1:0]  i_enq_prd,
    input  logic [ROB_WIDTH-1:0]   i_enq_rob_tag,
    input  logic [ROB_WIDTH-1:0]   i_rob_head,
    input  logic                   i_flush,
    output logic                   o_lsu_valid,
    output logic                   o_lsu_is_store,
    output logic [DATA_WIDTH-1:0]  o_lsu_base,
    output logic [DATA_WIDTH-1:0]  o_lsu_offset,
    output logic [DATA_WIDTH-1:0]  o_lsu_sdata,
    output logic [PREG_WIDTH-1:0]  o_lsu_prd,
    output logic [ROB_WIDTH-1:0]   o_lsu_rob_tag,
    input  logic                   i_lsu_wb_valid,
    output logic                   o_wb_valid,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [1:0]             o_inflight
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    mem_op_t          enq_op;
    mem_op_t          head_op;
    logic [CNT_W-1:0] count;
    logic             enq_fire;
    logic             empty;
    logic             tag_match;
    logic             issue;
    lsu_state_e       state;

    logic             vld_p1, vld_p2;
    logic             st_p1;
    logic             kill_p1, kill_p2;

    assign o_enq_ready = (count != CNT_W'(DEPTH)) && !i_flush;
    assign enq_fire    = i_enq_valid && o_enq_ready;
    assign empty       = (count == '0);
    assign tag_match   = (head_op.rob_tag == i_rob_head);

    // Pack the dispatched operands into a queue record.
    always_comb begin
        enq_op          = '0;
        enq_op.is_store = i_enq_is_store;
        enq_op.base     = i_enq_base;
        enq_op.offset   = i_enq_offset;
        enq_op.sdata    = i_enq_sdata;
        enq_op.prd      = i_enq_prd;
        enq_op.rob_tag  = i_enq_rob_tag;
    end

    lsu_op_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (i_flush),
        .push    (enq_fire),
        .push_op (enq_op),
        .pop     (issue),
        .head_op (head_op),
        .count   (count)
    );

    // Issue decision from the head entry; in STORE_WAIT the head is the
    // waiting store, so only the ROB-head match matters.
    always_comb begin
        issue = 1'b0;
        if (!i_flush && !empty) begin
            if (state == ST_STORE_WAIT) issue = tag_match;
            else                        issue = !head_op.is_store || tag_match;
        end
    end

    // Store-wait FSM: park when a store reaches the head before it is the
    // oldest ROB entry, resume once it is.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:
                    if (!empty && head_op.is_store && !tag_match) state <= ST_STORE_WAIT;
                ST_STORE_WAIT:
                    if (tag_match) state <= ST_RUN;
                default:
                    state <= ST_RUN;
            endcase
        end
    end

    // Kill tracking aligned with the two LSU stages. A fresh issue never
    // coincides with a flush, so stage 1 enters un-killed; a flush marks
    // in-flight loads only, since issued stores are already committed.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            st_p1   <= 1'b0;
            kill_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            kill_p2 <= 1'b0;
        end else begin
            // issue -> LSU stage 1
            vld_p1  <= issue;
            st_p1   <= issue && head_op.is_store;
            kill_p1 <= 1'b0;
            // LSU stage 1 -> LSU stage 2 (writeback)
            vld_p2  <= vld_p1;
            kill_p2 <= vld_p1 && !st_p1 && (kill_p1 || i_flush);
        end
    end

    assign o_lsu_valid    = issue;
    assign o_lsu_is_store = head_op.is_store;
    assign o_lsu_base     = head_op.base;
    assign o_lsu_offset   = head_op.offset;
    assign o_lsu_sdata    = head_op.sdata;
    assign o_lsu_prd      = head_op.prd;
    assign o_lsu_rob_tag  = head_op.rob_tag;

    assign o_wb_valid = i_lsu_wb_valid && !kill_p2;
    assign o_count    = count;
    assign o_inflight = {1'b0, vld_p1} + {1'b0, vld_p2};

endmodule

// File: tb/tb_lsu_scheduler.sv
// Directed bench for lsu_scheduler with an issue-order scoreboard.
module tb_lsu_scheduler;

    localparam int DW    = 32;
    localparam int RW    = 4;
    localparam int PW    = 7;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          i_enq_valid;
    logic          o_enq_ready;
    logic          i_enq_is_store;
    logic [DW-1:0] i_enq_base, i_enq_offset, i_enq_sdata;
    logic [PW-1:0] i_enq_prd;
    logic [RW-1:0] i_enq_rob_tag;
    logic [RW-1:0] i_rob_head;
    logic          i_flush;
    logic          o_lsu_valid;
    logic          o_lsu_is_store;
    logic [DW-1:0] o_lsu_base, o_lsu_offset, o_lsu_sdata;
    logic [PW-1:0] o_lsu_prd;
    logic [RW-1:0] o_lsu_rob_tag;
    logic          i_lsu_wb_valid;
    logic          o_wb_valid;
    logic [2:0]    o_count;
    logic [1:0]    o_inflight;

    lsu_scheduler #(
        .DATA_WIDTH (DW),
        .ROB_WIDTH  (RW),
        .PREG_WIDTH (PW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_enq_valid    (i_enq_valid),
        .o_enq_ready    (o_enq_ready),
        .i_enq_is_store (i_enq_is_store),
        .i_enq_base     (i_enq_base),
        .i_enq_offset   (i_enq_offset),
        .i_enq_sdata    (i_enq_sdata),
        .i_enq_prd      (i_enq_prd),
        .i_enq_rob_tag  (i_enq_rob_tag),
        .i_rob_head     (i_rob_head),
        .i_flush        (i_flush),
        .o_lsu_valid    (o_lsu_valid),
        .o_lsu_is_store (o_lsu_is_store),
        .o_lsu_base     (o_lsu_base),
        .o_lsu_offset   (o_lsu_offset),
        .o_lsu_sdata    (o_lsu_sdata),
        .o_lsu_prd      (o_lsu_prd),
        .o_lsu_rob_tag  (o_lsu_rob_tag),
        .i_lsu_wb_valid (i_lsu_wb_valid),
        .o_wb_valid     (o_wb_valid),
        .o_count        (o_count),
        .o_inflight     (o_inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [107:0] sb [$];

    function automatic logic [DW-1:0] f_base(input logic [3:0] tag);
        return 32'h1000_0000 | (32'(tag) << 8);
    endfunction
    function automatic logic [DW-1:0] f_off(input logic [3:0] tag);
        return 32'(tag) + 32'd3;
    endfunction
    function automatic logic [DW-1:0] f_sd(input logic [3:0] tag);
        return 32'hA5A5_0000 | 32'(tag);
    endfunction
    function automatic logic [PW-1:0] f_prd(input logic [3:0] tag);
        return {3'b101, tag};
    endfunction
    function automatic logic [107:0] pack_op(input logic st, input logic [3:0] tag);
        return {st, tag, f_prd(tag), f_base(tag), f_off(tag), f_sd(tag)};
    endfunction

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic enq(input logic st, input logic [3:0] tag, input bit accept);
        i_enq_valid    = 1'b1;
        i_enq_is_store = st;
        i_enq_rob_tag  = tag;
        i_enq_base     = f_base(tag);
        i_enq_offset   = f_off(tag);
        i_enq_sdata    = f_sd(tag);
        i_enq_prd      = f_prd(tag);
        if (accept) sb.push_back(pack_op(st, tag));
    endtask

    task automatic no_enq();
        i_enq_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Every issue must match the oldest outstanding expected op.
    always @(negedge clk) begin
        if (!reset && o_lsu_valid) begin
            if (sb.size() == 0) begin
                chk("issue_with_empty_sb", {127'd0, o_lsu_valid}, 128'd0);
            end else begin
                chk("issue_order",
                    {20'd0, o_lsu_is_store, o_lsu_rob_tag, o_lsu_prd, o_lsu_base, o_lsu_offset, o_lsu_sdata},
                    {20'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        i_flush = 1'b0;
        i_lsu_wb_valid = 1'b0;
        i_rob_head = '0;
        i_enq_valid = 1'b0;
        i_enq_is_store = 1'b0;
        i_enq_base = '0;
        i_enq_offset = '0;
        i_enq_sdata = '0;
        i_enq_prd = '0;
        i_enq_rob_tag = '0;
        repeat (3) tick();
        reset = 1'b0;
        samp();
        chk("rst_count", o_count, 0);
        chk("rst_inflight", o_inflight, 0);
        chk("rst_valid", o_lsu_valid, 0);
        chk("rst_wb_valid", o_wb_valid, 0);
        chk("rst_ready", o_enq_ready, 1);
        tick();

        // Four back-to-back loads issue on consecutive cycles
        i_rob_head = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) enq(1'b0, 4'(i + 1), 1'b1);
            else no_enq();
            i_lsu_wb_valid = (i == 3);
            samp();
            chk("r20_valid", o_lsu_valid, (i >= 1 && i <= 4));
            chk("r20_ready", o_enq_ready, 1);
            if (i == 3) begin
                chk("r20_wb_pass", o_wb_valid, 1);
                chk("r20_inflight2", o_inflight, 2);
            end
            tick();
        end
        i_lsu_wb_valid = 1'b0;
        samp();
        chk("r20_empty", o_count, 0);
        tick();

        // Store waits at head, queue fills, fifth op held back
        i_rob_head = 4'd1;
        enq(1'b1, 4'd3, 1'b1);
        samp(); chk("r21_valid0", o_lsu_valid, 0); tick();
        for (int i = 0; i < 3; i++) begin
            enq(1'b0, 4'(i + 4), 1'b1);
            samp(); chk("r21_wait", o_lsu_valid, 0); tick();
        end
        enq(1'b0, 4'd7, 1'b0);
        samp();
        chk("r21_full_count", o_count, 4);
        chk("r21_full_ready", o_enq_ready, 0);
        chk("r21_full_valid", o_lsu_valid, 0);
        tick();
        i_rob_head = 4'd3;
        enq(1'b0, 4'd7, 1'b0);
        samp();
        chk("r21_store_issue", o_lsu_valid, 1);
        chk("r21_store_type", o_lsu_is_store, 1);
        chk("r21_still_full", o_enq_ready, 0);
        tick();
        enq(1'b0, 4'd7, 1'b1);
        samp();
        chk("r21_ready_back", o_enq_ready, 1);
        chk("r21_load_issue", o_lsu_valid, 1);
        tick();
        no_enq();
        samp(); chk("r21_enq_deq_count", o_count, 3); tick();
        repeat (2) begin samp(); tick(); end
        samp(); chk("r21_drained", o_count, 0); tick();

        // Store then load: load must not bypass the waiting store
        i_rob_head = 4'd0;
        enq(1'b1, 4'd2, 1'b1);
        samp(); chk("r22_c0", o_lsu_valid, 0); tick();
        enq(1'b0, 4'd5, 1'b1);
        samp(); chk("r22_c1", o_lsu_valid, 0); tick();
        no_enq();
        samp(); chk("r22_c2", o_lsu_valid, 0); chk("r22_count", o_count, 2); tick();
        i_rob_head = 4'd2;
        samp(); chk("r22_st_valid", o_lsu_valid, 1); chk("r22_st_type", o_lsu_is_store, 1); tick();
        samp(); chk("r22_ld_valid", o_lsu_valid, 1); chk("r22_ld_type", o_lsu_is_store, 0); tick();
        samp(); chk("r22_empty", o_lsu_valid, 0); tick();

        // Flush after a load issue: its writeback is killed
        i_rob_head = 4'd0;
        enq(1'b0, 4'd7, 1'b1);
        samp(); tick();
        enq(1'b0, 4'd8, 1'b1);
        samp(); chk("r23_issue", o_lsu_valid, 1); tick();
        enq(1'b0, 4'd10, 1'b0);
        i_flush = 1'b1;
        sb.delete();
        samp();
        chk("r23_flush_noissue", o_lsu_valid, 0);
        chk("r23_flush_noready", o_enq_ready, 0);
        chk("r23_inflight1", o_inflight, 1);
        tick();
        no_enq();
        i_flush = 1'b0;
        i_lsu_wb_valid = 1'b1;
        samp();
        chk("r23_wb_killed", o_wb_valid, 0);
        chk("r23_count0", o_count, 0);
        tick();
        i_lsu_wb_valid = 1'b0;
        samp(); chk("r23_inflight0", o_inflight, 0); tick();

        // Flush after a store issue: store writeback survives
        i_rob_head = 4'd9;
        enq(1'b1, 4'd9, 1'b1);
        samp(); tick();
        no_enq();
        samp(); chk("r13_st_issue", o_lsu_valid, 1); tick();
        i_flush = 1'b1;
        samp(); tick();
        i_flush = 1'b0;
        i_lsu_wb_valid = 1'b1;
        samp(); chk("r13_st_not_killed", o_wb_valid, 1); tick();
        i_lsu_wb_valid = 1'b0;

        // Pointer wrap with continuous enqueue/dequeue
        for (int i = 0; i < 12; i++) begin
            if (i < 10) enq(1'b0, 4'(i), 1'b1);
            else no_enq();
            samp();
            chk("r24_count_le4", {127'd0, (o_count <= 3'd4)}, 128'd1);
            chk("r24_valid", o_lsu_valid, (i >= 1 && i <= 10));
            tick();
        end

        // Reset while holding three ops
        i_rob_head = 4'd15;
        enq(1'b1, 4'd14, 1'b1);
        samp(); tick();
        enq(1'b0, 4'd1, 1'b1);
        samp(); tick();
        enq(1'b0, 4'd2, 1'b1);
        samp(); tick();
        no_enq();
        samp();
        chk("r25_count3", o_count, 3);
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        samp();
        chk("r25_count0", o_count, 0);
        chk("r25_valid0", o_lsu_valid, 0);
        chk("r25_ready1", o_enq_ready, 1);
        tick();
        samp();
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_scheduler.md
LSU_SCHEDULER -- requirements
Module: lsu_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 DATA_WIDTH, 32, address/data width
 ROB_WIDTH, 4, ROB tag width
 PREG_WIDTH, 7, physical register index width
 DEPTH, 4, memory-op queue entries (power of two)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
 clk  in  1  clock
 reset  in  1  reset, synchronous, active-high
 i_enq_valid  in  1  dispatch offers a memory op
 o_enq_ready  out  1  queue not full
 i_enq_is_store  in  1  1=store, 0=load
 i_enq_base  in  DATA_WIDTH  rs1 value
 i_enq_offset  in  DATA_WIDTH  immediate
 i_enq_sdata  in  DATA_WIDTH  store data (ignored for loads)
 i_enq_prd  in  PREG_WIDTH  load destination preg
 i_enq_rob_tag  in  ROB_WIDTH  op ROB tag
 i_rob_head  in  ROB_WIDTH  current ROB head tag
 i_flush  in  1  mispredict flush
 o_lsu_valid  out  1  issue to LSU pipe
 o_lsu_is_store  out  1  issued op type
 o_lsu_base, o_lsu_offset, o_lsu_sdata  out  DATA_WIDTH each  issued operands
 o_lsu_prd  out  PREG_WIDTH  issued destination
 o_lsu_rob_tag  out  ROB_WIDTH  issued tag
 i_lsu_wb_valid  in  1  LSU writeback valid (2 cycles after issue)
 o_wb_valid  out  1  i_lsu_wb_valid gated by kill tracking
 o_count  out  $clog2(DEPTH)+1  queue occupancy
 o_inflight  out  2  ops in LSU pipe

Function
REQ-003 Queue SHALL be in-order circular FIFO, DEPTH entries, head/tail pointers wrap modulo DEPTH.
REQ-004 Enqueue SHALL occur when i_enq_valid && o_enq_ready; o_enq_ready = (o_count != DEPTH) && !i_flush.
REQ-005 FSM SHALL have states RUN and STORE_WAIT.
REQ-006 RUN: non-empty head load SHALL issue same cycle (o_lsu_valid=1, combinational from head entry), dequeued at clock edge.
REQ-007 RUN: head store with rob_tag==i_rob_head SHALL issue; otherwise no issue, next state STORE_WAIT.
REQ-008 STORE_WAIT: issue SHALL be held until rob_tag==i_rob_head, then store issues and state returns to RUN.
REQ-009 At most one issue per cycle; loads SHALL never bypass an older store (strict program order).
REQ-010 Simultaneous enqueue and dequeue SHALL leave o_count unchanged; enqueue into empty queue SHALL not issue before next cycle.
REQ-011 i_flush SHALL empty queue (pointers and count to 0), force RUN, suppress issue and enqueue that cycle.
REQ-012 Kill tracking: 2-bit shift register aligned with LSU stages; on flush both in-flight slots SHALL be marked killed; o_wb_valid = i_lsu_wb_valid && !kill[stage2].
REQ-013 Flush SHALL kill only loads already issued; a store issued is committed and is never flushed (stores issue only at ROB head).
REQ-014 o_inflight SHALL equal number of valid issues in the 2-cycle shadow (0..2).
REQ-015 o_lsu_* data outputs SHALL be don't-care when o_lsu_valid=0, but driven to head entry values.

Reset
REQ-016 On reset: FSM=RUN, pointers=0, o_count=0, o_inflight=0, kill bits=0, o_lsu_valid=0, o_wb_valid=0, o_enq_ready=1.
REQ-017 Reset mid-operation SHALL discard all queued and in-flight ops; queue payload storage need not be cleared.

Structure
REQ-018 Shared package lsu_pkg SHALL hold mem_op_t struct (is_store, base, offset, sdata, prd, rob_tag) and FSM state enum.
REQ-019 One sub-module, lsu_op_fifo (generic circular FIFO of mem_op_t with count), SHALL be instantiated; FSM and kill tracking stay in lsu_scheduler.

Verification
REQ-020 Enqueue 4 loads tags 1..4 back-to-back -> o_lsu_valid on 4 consecutive cycles starting cycle after first enqueue, tags 1,2,3,4; o_enq_ready=0 never seen.
REQ-021 Enqueue 5 ops while head store tag 3 waits with i_rob_head=1 -> o_count=4, o_enq_ready=0, 5th held; set i_rob_head=3 -> store issues, ready returns next cycle.
REQ-022 Store tag 2 then load tag 5, i_rob_head=0 -> no issue (STORE_WAIT); i_rob_head=2 -> store issues, load issues next cycle.
REQ-023 Issue load, flush 1 cycle later, i_lsu_wb_valid=1 two cycles after issue -> o_wb_valid=0, o_count=0, o_inflight returns 0.
REQ-024 Pointer wrap: enqueue/dequeue 10 ops continuously -> order preserved, o_count never exceeds 4.
REQ-025 Assert reset while queue holds 3 ops -> next cycle o_count=0, o_lsu_valid=0, o_enq_ready=1.
